count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_arbiter.sv | 112 +++++++++++
 tb/tb_count_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count_arbiter.sv
// count_arbiter: two-requester round-robin arbiter that grants one
// counting interval at a time. The winner's len is latched as the limit.
// The shared counter then runs 0..limit while the winner keeps its request.
// Reaching the limit ends the interval with a one-cycle done pulse.
// Dropping the request aborts the interval and gives no done pulse.
module count_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             last_q;   // requester granted most recently
  logic             win_q;    // requester owning the current interval

  logic             grant_valid;
  logic             grant_idx;
  logic [WIDTH-1:0] grant_len;

  // Arbitration for the IDLE state; a tie goes to whoever did not win last.
  always_comb begin
    grant_valid = (req != 2'b00);
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_q;
      default: grant_idx = 1'b0;
    endcase
    grant_len = grant_idx ? len1 : len0;
  end

  // Single FSM register block. Every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= '0;
      limit_q <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          if (grant_valid) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            gnt_q   <= grant_idx ? 2'b10 : 2'b01;
            limit_q <= grant_len;
            last_q  <= grant_idx;
            win_q   <= grant_idx;
          end
        end
        RUN: begin
          if (!req[win_q]) begin
            // Abort takes priority over completion, even at the limit.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gnt_q   <= 2'b00;
            count_q <= '0;
          end else if (count_q == limit_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            gnt_q   <= 2'b00;
            count_q <= '0;
            done_q  <= win_q ? 2'b10 : 2'b01;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= 2'b00;
          count_q <= '0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter.
// A vector table covers grants, round-robin, abort and len/req isolation.
// Hand-written sequences cover the long runs and asynchronous reset.
module tb_count_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] count;
  logic [1:0] done;

  int n_checks;
  int n_fails;

  count_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] count;
    logic [1:0] done;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [1:0] r, logic [3:0] l0, logic [3:0] l1,
                              logic [1:0] g, logic b, logic [3:0] c, logic [1:0] d);
    vec_t v;
    v.req = r; v.len0 = l0; v.len1 = l1;
    v.gnt = g; v.busy = b; v.count = c; v.done = d;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g, input logic b,
                         input logic [3:0] c, input logic [1:0] d);
    chk({tag, ".gnt"},   int'(gnt),   int'(g));
    chk({tag, ".busy"},  int'(busy),  int'(b));
    chk({tag, ".count"}, int'(count), int'(c));
    chk({tag, ".done"},  int'(done),  int'(d));
    $display("%s: req=%b gnt=%b busy=%b count=%0d done=%b", tag, req, gnt, busy, count, done);
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    req   = 2'b00;
    len0  = 4'd0;
    len1  = 4'd0;

    // Fill the table. Each row is the inputs applied and the outputs after the next edge.
    // Start of the table: len0=3, one interval of 4 cycles.
    vecs[0]  = mk(2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd0, 2'b00);
    vecs[1]  = mk(2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd1, 2'b00);
    vecs[2]  = mk(2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd2, 2'b00);
    vecs[3]  = mk(2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 2'b00);
    vecs[4]  = mk(2'b01, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
    vecs[5]  = mk(2'b00, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00);
    // len1=0: one-cycle grant, then done.
    vecs[6]  = mk(2'b10, 4'd3, 4'd0, 2'b10, 1'b1, 4'd0, 2'b00);
    vecs[7]  = mk(2'b10, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 2'b10);
    vecs[8]  = mk(2'b00, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00);
    // Both requesting: the last grant went to 1, so 0 wins, then 1, then 0.
    vecs[9]  = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd0, 2'b00);
    vecs[10] = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd1, 2'b00);
    vecs[11] = mk(2'b11, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 2'b01);
    vecs[12] = mk(2'b11, 4'd1, 4'd2, 2'b10, 1'b1, 4'd0, 2'b00);
    vecs[13] = mk(2'b11, 4'd1, 4'd2, 2'b10, 1'b1, 4'd1, 2'b00);
    vecs[14] = mk(2'b11, 4'd1, 4'd2, 2'b10, 1'b1, 4'd2, 2'b00);
    vecs[15] = mk(2'b11, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 2'b10);
    vecs[16] = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd0, 2'b00);
    vecs[17] = mk(2'b00, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 2'b00);
    // Requester 0 with len0=4; len0 and req[1] change mid-run and are ignored.
    vecs[18] = mk(2'b01, 4'd4, 4'd2, 2'b01, 1'b1, 4'd0, 2'b00);
    vecs[19] = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd1, 2'b00);
    vecs[20] = mk(2'b01, 4'd1, 4'd2, 2'b01, 1'b1, 4'd2, 2'b00);
    vecs[21] = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd3, 2'b00);
    vecs[22] = mk(2'b11, 4'd1, 4'd2, 2'b01, 1'b1, 4'd4, 2'b00);
    vecs[23] = mk(2'b11, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 2'b01);
    vecs[24] = mk(2'b11, 4'd1, 4'd2, 2'b10, 1'b1, 4'd0, 2'b00);
    vecs[25] = mk(2'b00, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 2'b00);
    // Abort exactly at count==limit (limit 0): abort wins, so there is no done pulse.
    vecs[26] = mk(2'b10, 4'd1, 4'd0, 2'b10, 1'b1, 4'd0, 2'b00);
    vecs[27] = mk(2'b00, 4'd1, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00);

    // Reset values while reset is held low.
    tick();
    tick();
    chk_all("reset", 2'b00, 1'b0, 4'd0, 2'b00);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req  = vecs[i].req;
      len0 = vecs[i].len0;
      len1 = vecs[i].len1;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].count, vecs[i].done);
    end

    // len0=15: abort at count=5.
    len0 = 4'd15;
    req  = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk_all($sformatf("abort5.c%0d", c), 2'b01, 1'b1, 4'(c), 2'b00);
    end
    req = 2'b00;
    tick();
    chk_all("abort5.end", 2'b00, 1'b0, 4'd0, 2'b00);

    // Full count to 15, then abort at count==limit.
    req = 2'b01;
    for (int c = 0; c <= 15; c++) begin
      tick();
      chk_all($sformatf("abort15.c%0d", c), 2'b01, 1'b1, 4'(c), 2'b00);
    end
    req = 2'b00;
    tick();
    chk_all("abort15.end", 2'b00, 1'b0, 4'd0, 2'b00);

    // Full count to 15 with no wrap, then done.
    req = 2'b01;
    for (int c = 0; c <= 15; c++) begin
      tick();
      chk_all($sformatf("full15.c%0d", c), 2'b01, 1'b1, 4'(c), 2'b00);
    end
    tick();
    chk_all("full15.end", 2'b00, 1'b0, 4'd0, 2'b01);
    req = 2'b00;
    tick();
    chk_all("full15.idle", 2'b00, 1'b0, 4'd0, 2'b00);

    // Asynchronous reset mid-run at count=7; requester 0 was granted last.
    req = 2'b01;
    for (int c = 0; c <= 7; c++) tick();
    chk_all("areset.pre", 2'b01, 1'b1, 4'd7, 2'b00);
    #2;
    reset = 1'b0;
    #1;
    chk_all("areset.now", 2'b00, 1'b0, 4'd0, 2'b00);
    tick();
    chk_all("areset.hold", 2'b00, 1'b0, 4'd0, 2'b00);
    reset = 1'b1;
    req   = 2'b11;
    len0  = 4'd2;
    len1  = 4'd2;
    tick();
    chk_all("areset.first", 2'b01, 1'b1, 4'd0, 2'b00);
    tick();
    chk_all("areset.next", 2'b01, 1'b1, 4'd1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
